// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package dmem_arb_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Requester IDs. The owner bit in a command carries one of these values.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // One accepted access. It is held in the command stage for one cycle.
    typedef struct packed {
        logic              owner;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of the data memory arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the memory.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic              req0, req1;
    logic              we0, we1;
    logic              lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        input  mem_read_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        output mem_read_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_address, mem_write_data, mem_write_enable, mem_read_enable
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant logic. It is purely combinational from the requests and the registered
// ownership/lock state. 'locked' marks a grant that was won through the lock rule
// against a waiting competitor.
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int MAX_LOCK   = 4
) (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       last_lock,
    input  logic [3:0] lock_cnt,
    output logic [1:0] gnt,
    output logic       locked
);
    localparam logic [3:0] MAX_L = 4'(MAX_LOCK);

    logic lock_hit;
    assign lock_hit = last_lock && req[last_owner] && (lock_cnt < MAX_L);

    // Single requester wins outright; contention is resolved by priority, lock, then rotation.
    always_comb begin
        gnt    = 2'b00;
        locked = 1'b0;
        if (req == 2'b11) begin
            if (FIXED_PRIO) begin
                gnt = 2'b01;
            end else if (lock_hit) begin
                gnt[last_owner] = 1'b1;
                locked          = 1'b1;
            end else begin
                gnt[~last_owner] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and one-stage sequencer in front of the 128x16 data memory.
// Accepted requests go into the command register. That register drives the memory
// for one cycle. Read data is captured one edge later and returned with an rvalid pulse.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int MAX_LOCK   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    logic [1:0] gnt;
    logic       locked;
    logic       any_gnt;
    logic       last_owner;
    logic       last_lock;
    logic [3:0] lock_cnt;
    logic       cmd_valid;
    cmd_t       cmd;
    cmd_t       nxt_cmd;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO), .MAX_LOCK(MAX_LOCK)) u_arb (
        .req        ({bus.req1, bus.req0}),
        .last_owner (last_owner),
        .last_lock  (last_lock),
        .lock_cnt   (lock_cnt),
        .gnt        (gnt),
        .locked     (locked)
    );

    assign any_gnt  = |gnt;
    assign bus.gnt0 = gnt[0];
    assign bus.gnt1 = gnt[1];

    // Select the winning requester's fields for the command register.
    always_comb begin
        nxt_cmd = '0;
        if (gnt[1]) nxt_cmd = '{owner: REQ_DMA, we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
        else        nxt_cmd = '{owner: REQ_CPU, we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
    end

    // Ownership and lock bookkeeping. The run count only grows on lock-won grants and is cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b1;
            last_lock  <= 1'b0;
            lock_cnt   <= 4'd0;
        end else begin
            if (any_gnt) begin
                last_owner <= gnt[1];
                last_lock  <= gnt[1] ? bus.lock1 : bus.lock0;
            end
            lock_cnt <= locked ? lock_cnt + 4'd1 : 4'd0;
        end
    end

    // Command stage. Address and data hold their last values when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd       <= '0;
        end else begin
            cmd_valid <= any_gnt;
            if (any_gnt) cmd <= nxt_cmd;
        end
    end

    assign bus.mem_address      = cmd.addr;
    assign bus.mem_write_data   = cmd.wdata;
    assign bus.mem_write_enable = cmd_valid & cmd.we;
    assign bus.mem_read_enable  = cmd_valid & ~cmd.we;

    // Capture read data and pulse rvalid toward whichever requester issued the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.rdata   <= '0;
        end else begin
            bus.rvalid0 <= cmd_valid & ~cmd.we & (cmd.owner == REQ_CPU);
            bus.rvalid1 <= cmd_valid & ~cmd.we & (cmd.owner == REQ_DMA);
            if (cmd_valid && !cmd.we) bus.rdata <= bus.mem_read_data;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. It holds a behavioural reference for the round-robin/lock
// instance, directed scenarios with literal expectations, and a fixed-priority instance.
module tb_dmem_arbiter;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter_if bus_fp();

    dmem_arbiter #(.FIXED_PRIO(1'b0), .MAX_LOCK(ML)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    dmem_arbiter #(.FIXED_PRIO(1'b1), .MAX_LOCK(ML)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

    // Memories behind each arbiter: combinational read, write on the rising edge.
    logic [15:0] mem_a [128] = '{default: '0};
    logic [15:0] mem_b [128] = '{default: '0};
    assign bus.mem_read_data    = mem_a[bus.mem_address[7:1]];
    assign bus_fp.mem_read_data = mem_b[bus_fp.mem_address[7:1]];
    always @(posedge clk) if (bus.mem_write_enable)    mem_a[bus.mem_address[7:1]]    <= bus.mem_write_data;
    always @(posedge clk) if (bus_fp.mem_write_enable) mem_b[bus_fp.mem_address[7:1]] <= bus_fp.mem_write_data;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registered state of the arbiter and memory, expressed as plain variables.
    bit          m_cv, m_owner, m_we, m_rv0, m_rv1, m_lockf;
    logic [15:0] m_addr, m_wdata, m_rdata;
    int          m_last, m_cnt;
    logic [15:0] mmem [128] = '{default: '0};

    // Compare on the falling edge, then advance the model to the next rising edge.
    always @(negedge clk) begin
        int  r0, r1, w;
        bit  lock_ok, locked;
        if (!rst_n) begin
            m_cv = 0; m_owner = 0; m_we = 0; m_rv0 = 0; m_rv1 = 0; m_lockf = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0; m_last = 1; m_cnt = 0;
        end
        r0 = int'(bus.req0); r1 = int'(bus.req1);
        lock_ok = m_lockf && ((m_last == 0) ? r0 != 0 : r1 != 0) && (m_cnt < ML);
        locked = 0;
        if (r0 != 0 && r1 != 0) begin
            if (lock_ok) begin w = m_last; locked = 1; end
            else w = 1 - m_last;
        end else if (r0 != 0) w = 0;
        else if (r1 != 0) w = 1;
        else w = -1;

        chk("gnt0",      32'(bus.gnt0),             32'(w == 0));
        chk("gnt1",      32'(bus.gnt1),             32'(w == 1));
        chk("mem_we",    32'(bus.mem_write_enable), 32'(m_cv && m_we));
        chk("mem_re",    32'(bus.mem_read_enable),  32'(m_cv && !m_we));
        chk("mem_addr",  32'(bus.mem_address),      32'(m_addr));
        chk("mem_wdata", 32'(bus.mem_write_data),   32'(m_wdata));
        chk("rvalid0",   32'(bus.rvalid0),          32'(m_rv0));
        chk("rvalid1",   32'(bus.rvalid1),          32'(m_rv1));
        chk("rdata",     32'(bus.rdata),            32'(m_rdata));

        if (rst_n) begin
            m_rv0 = m_cv && !m_we && !m_owner;
            m_rv1 = m_cv && !m_we && m_owner;
            if (m_cv && !m_we) m_rdata = mmem[m_addr[7:1]];
            if (m_cv && m_we)  mmem[m_addr[7:1]] = m_wdata;
            m_cv = (w >= 0);
            if (w == 0) begin m_owner = 0; m_we = bus.we0; m_addr = bus.addr0; m_wdata = bus.wdata0; m_lockf = bus.lock0; end
            if (w == 1) begin m_owner = 1; m_we = bus.we1; m_addr = bus.addr1; m_wdata = bus.wdata1; m_lockf = bus.lock1; end
            if (w >= 0) m_last = w;
            m_cnt = locked ? m_cnt + 1 : 0;
        end
    end

    // Log of returned reads {owner, data} and of write-enable cycles, for scenario checks.
    logic [16:0] rv_log [$];
    int          we_cycles = 0;
    always @(negedge clk) begin
        if (bus.rvalid0) rv_log.push_back({1'b0, bus.rdata});
        if (bus.rvalid1) rv_log.push_back({1'b1, bus.rdata});
        if (bus.mem_write_enable) we_cycles++;
    end

    logic g0, g1, h0, h1;

    task automatic tick();
        @(negedge clk);
        g0 = bus.gnt0; g1 = bus.gnt1; h0 = bus_fp.gnt0; h1 = bus_fp.gnt1;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input bit r, input bit we, input bit lk, input logic [15:0] a, input logic [15:0] d);
        bus.req0 = r; bus.we0 = we; bus.lock0 = lk; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set1(input bit r, input bit we, input bit lk, input logic [15:0] a, input logic [15:0] d);
        bus.req1 = r; bus.we1 = we; bus.lock1 = lk; bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic idle_fp();
        bus_fp.req0 = 0; bus_fp.we0 = 0; bus_fp.lock0 = 0; bus_fp.addr0 = 0; bus_fp.wdata0 = 0;
        bus_fp.req1 = 0; bus_fp.we1 = 0; bus_fp.lock1 = 0; bus_fp.addr1 = 0; bus_fp.wdata1 = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); idle_fp();
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin
        logic [6:0] gl0, gl1;
        logic [5:0] ov;
        int         w0;

        rst_n = 0;
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); idle_fp();
        #1;
        chk("rst_we",    32'(bus.mem_write_enable), 0);
        chk("rst_re",    32'(bus.mem_read_enable),  0);
        chk("rst_addr",  32'(bus.mem_address),      0);
        chk("rst_rdata", 32'(bus.rdata),            0);
        chk("rst_rv",    32'({bus.rvalid1, bus.rvalid0}), 0);

        // 1: write then read from requester 0
        do_reset(); rv_log.delete(); w0 = we_cycles;
        set0(1, 1, 0, 16'h00A4, 16'hBEEF); tick(); chk("t1_gnt_wr", 32'({g1, g0}), 32'h1);
        set0(1, 0, 0, 16'h00A4, 16'h0000); tick(); chk("t1_gnt_rd", 32'({g1, g0}), 32'h1);
        set0(0, 0, 0, 0, 0); drain();
        chk("t1_we_cycles", 32'(we_cycles - w0), 1);
        chk("t1_rv_count", 32'(rv_log.size()), 1);
        if (rv_log.size() >= 1) chk("t1_rv", 32'(rv_log[0]), 32'h0BEEF);

        // 2: round-robin under continuous contention
        do_reset(); rv_log.delete(); gl1 = '0;
        set0(1, 0, 0, 16'h0002, 0); set1(1, 0, 0, 16'h0004, 0);
        for (int i = 0; i < 6; i++) begin tick(); gl1 = {gl1[5:0], g1}; end
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); drain();
        chk("t2_gnt_seq", 32'(gl1[5:0]), 32'b010101);
        chk("t2_rv_count", 32'(rv_log.size()), 6);
        ov = '0;
        foreach (rv_log[i]) ov = {ov[4:0], rv_log[i][16]};
        chk("t2_rv_order", 32'(ov), 32'b010101);

        // 3: lock bounded at MAX_LOCK consecutive locked grants
        do_reset(); gl0 = '0; gl1 = '0;
        set0(1, 0, 1, 16'h0006, 0); set1(1, 0, 0, 16'h0008, 0);
        for (int i = 0; i < 7; i++) begin tick(); gl0 = {gl0[5:0], g0}; gl1 = {gl1[5:0], g1}; end
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0); drain();
        chk("t3_gnt0_seq", 32'(gl0), 32'b1111101);
        chk("t3_gnt1_seq", 32'(gl1), 32'b0000010);

        // 4: write then read-after-write from requester 1
        do_reset(); rv_log.delete();
        set1(1, 1, 0, 16'h0010, 16'h1234); tick(); chk("t4_gnt_wr", 32'({g1, g0}), 32'h2);
        set1(1, 0, 0, 16'h0010, 16'h0000); tick(); chk("t4_gnt_rd", 32'({g1, g0}), 32'h2);
        set1(0, 0, 0, 0, 0); drain();
        chk("t4_rv_count", 32'(rv_log.size()), 1);
        if (rv_log.size() >= 1) chk("t4_rv", 32'(rv_log[0]), 32'h11234);

        // 5: reset while a write sits in the command stage
        do_reset(); rv_log.delete();
        set0(1, 1, 0, 16'h0020, 16'h5555); tick();
        chk("t5_we_before", 32'(bus.mem_write_enable), 1);
        set0(0, 0, 0, 0, 0); rst_n = 0; #1;
        chk("t5_we_reset",   32'(bus.mem_write_enable), 0);
        chk("t5_addr_reset", 32'(bus.mem_address), 0);
        chk("t5_rv_reset",   32'({bus.rvalid1, bus.rvalid0}), 0);
        @(posedge clk); #1 rst_n = 1;
        set0(1, 0, 0, 16'h0020, 0); tick(); set0(0, 0, 0, 0, 0); drain();
        chk("t5_rv_count", 32'(rv_log.size()), 1);
        if (rv_log.size() >= 1) chk("t5_rv", 32'(rv_log[0]), 32'h00000);

        // 6: fixed-priority instance
        do_reset();
        bus_fp.req0 = 1; bus_fp.addr0 = 16'h0002; bus_fp.req1 = 1; bus_fp.addr1 = 16'h0004;
        for (int i = 0; i < 3; i++) begin tick(); chk("t6_gnt_both", 32'({h1, h0}), 32'h1); end
        bus_fp.req0 = 0; tick(); chk("t6_gnt_dma", 32'({h1, h0}), 32'h2);
        idle_fp(); drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the 128x16 data memory. It shares the memory between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader). The policy is round-robin with optional bounded lock. Each accepted request is registered into a single command stage that drives the memory for one cycle. Read data is captured and returned with a valid pulse to the requester that issued it.

Parameters:
FIXED_PRIO, 0, 1 = requester 0 always wins ties; 0 = round-robin.
MAX_LOCK, 4, maximum consecutive locked grants to one requester while the other is waiting (range 1..15).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0, req1  in  1 each  access request; held until granted
we0, we1  in  1 each  1 = write, 0 = read; valid with req
lock0, lock1  in  1 each  request to keep ownership for the next access
addr0, addr1  in  16 each  byte address (memory uses bits [7:1])
wdata0, wdata1  in  16 each  write data
gnt0, gnt1  out  1 each  combinational: request accepted at this clock edge
rvalid0, rvalid1  out  1 each  one-cycle pulse; rdata holds read result
rdata  out  16  captured read data, shared by both requesters
mem_address  out  16  to memory address
mem_write_data  out  16  to memory write_data
mem_write_enable  out  1  to memory write_enable
mem_read_enable  out  1  to memory read_enable
mem_read_data  in  16  from memory read_data (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - cmd_valid=0, so mem_write_enable=0, mem_read_enable=0, mem_address=0, mem_write_data=0.
  - rvalid0/1=0, rdata=0, last_owner=1 (requester 0 wins the first tie), lock_cnt=0.
- Pipeline: throughput is 1 access/cycle. An accept can happen every cycle, including the cycle the command stage is busy.
  - Cycle k: reqN=1 and arbitration selects N, so gntN=1.
  - Edge end of k: command register captures {owner, we, addr, wdata}; cmd_valid=1.
  - Cycle k+1: memory driven from the command register. mem_write_enable=we, mem_read_enable=~we.
  - Edge end of k+1: the write commits in memory. For a read, rdata <= mem_read_data.
  - Cycle k+2: rvalidN=1 for reads only. Writes produce no rvalid.
- Idle: with no request, cmd_valid=0 next cycle, both enables are 0, and address/wdata hold their last values.
- Arbitration (gnt is a combinational function of req and registered state):
  - Only one requester: it is granted.
  - Both requesting, FIXED_PRIO=1: requester 0.
  - Both requesting, FIXED_PRIO=0, lock rule applies: grant last_owner.
  - Both requesting, otherwise: grant the requester that is not last_owner.
  - Lock rule applies when last_owner asserted lock with its previous accepted request, it is requesting now, and lock_cnt < MAX_LOCK.
  - last_owner updates on every grant.
  - lock_cnt increments on a locked grant while the other requester is waiting. It clears on any non-locked grant, and whenever the other requester is not requesting.
- Never both gnt0 and gnt1 high. gntN implies reqN.
- Ordering: a write accepted in cycle k followed by a read of the same address accepted in cycle k+1 returns the new data. The write commits before the read is driven.
- Address: passed through unmodified. bit0 and bits [15:8] are ignored by memory and alias; no error is raised.
- Reset mid-operation: asserting rst_n=0 clears cmd_valid immediately. A pending write is dropped (no enable after reset), and pending rvalids are cancelled.
- A requester deasserting req before grant withdraws it with no side effects.

Decomposition:
- Package dmem_arb_pkg holds:
  - ADDR_W=16, DATA_W=16.
  - Requester ID constants REQ_CPU=0, REQ_DMA=1.
  - Packed struct type for the command register {owner, we, addr, wdata}.
- Sub-module rr_arb2 is natural. It is the pure grant logic: req, last_owner, lock state and FIXED_PRIO in; gnt out.
- Counters, the command register and read capture stay in dmem_arbiter.

Test Plan:
1. Reset then single write/read. req0: write 0x00A4 <- 0xBEEF. Next cycle: read 0x00A4.
   -> gnt0 in both cycles; mem_write_enable high for one cycle; rvalid0 two cycles after the read grant with rdata=0xBEEF; rvalid1 never.
2. Round-robin. req0 and req1 both held high for 6 cycles, reads, no lock.
   -> grants alternate 0,1,0,1,0,1 starting with 0; rvalid pulses follow the same order.
3. Lock bound. MAX_LOCK=4; req0 with lock0=1 continuously; req1 held.
   -> after requester 0's first grant, 4 more locked grants, then gnt1; then requester 0 resumes.
4. Back-to-back hazard. req1: write 0x0010 <- 0x1234, then read 0x0010 in the next cycle.
   -> rdata=0x1234 with rvalid1, no stale 0x0000.
5. Reset mid-access. Grant a write 0x0020 <- 0x5555; pull rst_n low before the next edge.
   -> mem_write_enable drops immediately; a later read of 0x0020 returns 0x0000; rvalids are 0.
6. FIXED_PRIO=1. Both requesting reads for 3 cycles.
   -> gnt0 all three cycles; gnt1 only once req0 drops.
